// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. Grants one byte per transmission, issues the launch pulse, waits
// for the transmitter's done pulse, and recovers via a watchdog if it never
// arrives. An optional packet lock keeps multi-byte messages contiguous.
module uart_tx_arbiter #(
    parameter int unsigned  N_REQ   = 4,
    parameter int unsigned  BPS     = 9600,
    parameter int unsigned  CLK_FRE = 50_000_000,
    parameter int unsigned  TO_BITS = 12,
    localparam int unsigned IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_en,
    input  logic               uart_tx_done,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic               lock_active,
    output logic               tx_timeout
);

    localparam int unsigned TO_CYC = (CLK_FRE / BPS) * TO_BITS;
    localparam int unsigned WDW    = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic               lock_q, lock_d;
    logic               en_q, en_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [WDW-1:0]     wd_inc;

    logic [N_REQ-1:0]   elig;
    logic               win_found;
    logic [IDW-1:0]     win_idx;

    // Eligible set: everyone valid when unlocked, only the lock owner when locked
    always_comb begin
        elig = req_valid;
        if (lock_q) begin
            elig = req_valid & (N_REQ'(1) << grant_q);
        end
    end

    // Round-robin search starting just after the last granted index
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(rr_q) + k) % N_REQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    assign wd_inc = wd_q + WDW'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        wd_d      = wd_q;
        en_d      = 1'b0;
        to_d      = 1'b0;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready = N_REQ'(1) << win_idx;
                    data_d    = req_data[8*win_idx +: 8];
                    grant_d   = win_idx;
                    rr_d      = win_idx;
                    lock_d    = ~req_last[win_idx];
                    en_d      = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_inc;
                if (uart_tx_done) begin
                    // Done beats a simultaneous watchdog expiry
                    state_d = ST_IDLE;
                end else if (wd_inc == WDW'(TO_CYC - 1)) begin
                    to_d    = 1'b1;
                    lock_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            grant_q <= '0;
            rr_q    <= IDW'(N_REQ - 1);
            lock_q  <= 1'b0;
            en_q    <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            en_q    <= en_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            wd_q    <= wd_d;
        end
    end

    assign uart_tx_data = data_q;
    assign uart_tx_en   = en_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign lock_active  = lock_q;
    assign tx_timeout   = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scaled-down clock/baud setting so
// the watchdog expires after 120 cycles ((1000/100)*12).
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int TO_CYC  = 120;
    localparam int LAT     = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic [7:0]   uart_tx_data;
    logic         uart_tx_en;
    logic         uart_tx_done;
    logic         busy;
    logic [1:0]   grant_id;
    logic         lock_active;
    logic         tx_timeout;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .BPS     (100),
        .CLK_FRE (1000),
        .TO_BITS (12)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_done (uart_tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .lock_active  (lock_active),
        .tx_timeout   (tx_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a launch pulse is seen; at = cycle of the pulse or -1
    task automatic wait_launch(input int budget, output int at);
        int n;
        at = -1;
        n  = 0;
        while (at < 0 && n < budget) begin
            step();
            if (uart_tx_en) at = cyc;
            n++;
        end
        check("launch_seen", 32'(at >= 0), 32'd1);
    endtask

    // Transmitter model: done pulse LAT cycles after the launch cycle
    task automatic finish_tx();
        repeat (LAT) step();
        uart_tx_done = 1'b1;
        step();
        uart_tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   32'(req_ready),    32'd0);
        check({tag, "_en"},      32'(uart_tx_en),   32'd0);
        check({tag, "_data"},    32'(uart_tx_data), 32'd0);
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_grant"},   32'(grant_id),     32'd0);
        check({tag, "_lock"},    32'(lock_active),  32'd0);
        check({tag, "_timeout"}, 32'(tx_timeout),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int at;
        int prev;
        int tat;
        int n;
        logic [7:0] exp_rr [5];
        logic [1:0] exp_gr [5];

        rst_n        = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        uart_tx_done = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("post_reset_busy", 32'(busy), 32'd0);

        // Round robin from rr_ptr = 3: grants 0,1,2,3,0
        exp_rr[0] = 8'h10; exp_rr[1] = 8'h11; exp_rr[2] = 8'h12; exp_rr[3] = 8'h13; exp_rr[4] = 8'h10;
        exp_gr[0] = 2'd0;  exp_gr[1] = 2'd1;  exp_gr[2] = 2'd2;  exp_gr[3] = 2'd3;  exp_gr[4] = 2'd0;
        req_last  = 4'hF;
        req_data  = 32'h13121110;
        req_valid = 4'hF;
        #1;
        check("rr_first_ready", 32'(req_ready), 32'h1);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_launch(5, at);
            check("rr_data",  32'(uart_tx_data), 32'(exp_rr[i]));
            check("rr_grant", 32'(grant_id),     32'(exp_gr[i]));
            if (i > 0) check("rr_spacing", 32'(at - prev), 32'(LAT + 2));
            prev = at;
            if (i == 4) req_valid = '0;
            finish_tx();
        end
        check("rr_idle_busy",  32'(busy),      32'd0);
        check("rr_idle_ready", 32'(req_ready), 32'd0);

        // Packet lock: req1 sends 55 (last=0) then 66, then 3, then 0
        req_data  = 32'hD30055A0;
        req_last  = 4'b1101;
        req_valid = 4'b1011;
        #1;
        check("lock_first_ready", 32'(req_ready), 32'h2);
        wait_launch(5, at);
        check("lock_b0_data",  32'(uart_tx_data), 32'h55);
        check("lock_b0_grant", 32'(grant_id),     32'd1);
        check("lock_b0_lock",  32'(lock_active),  32'd1);
        req_valid = 4'b1001;
        finish_tx();
        check("lock_starve_ready", 32'(req_ready),   32'd0);
        check("lock_starve_lock",  32'(lock_active), 32'd1);
        check("lock_starve_busy",  32'(busy),        32'd0);
        step();
        step();
        check("lock_starve_ready2", 32'(req_ready), 32'd0);
        req_data  = 32'hD30066A0;
        req_last  = 4'b1111;
        req_valid = 4'b1011;
        #1;
        check("lock_second_ready", 32'(req_ready), 32'h2);
        wait_launch(5, at);
        check("lock_b1_data",  32'(uart_tx_data), 32'h66);
        check("lock_b1_grant", 32'(grant_id),     32'd1);
        check("lock_b1_lock",  32'(lock_active),  32'd0);
        finish_tx();
        wait_launch(5, at);
        check("lock_next_data",  32'(uart_tx_data), 32'hD3);
        check("lock_next_grant", 32'(grant_id),     32'd3);
        finish_tx();
        wait_launch(5, at);
        check("lock_last_data",  32'(uart_tx_data), 32'hA0);
        check("lock_last_grant", 32'(grant_id),     32'd0);
        req_valid = '0;
        finish_tx();

        // Single byte from requester 2
        req_data  = 32'h00A50000;
        req_last  = 4'hF;
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_idle_busy", 32'(busy), 32'd0);
        step();
        check("single_en",    32'(uart_tx_en),   32'd1);
        check("single_data",  32'(uart_tx_data), 32'hA5);
        check("single_grant", 32'(grant_id),     32'd2);
        check("single_busy",  32'(busy),         32'd1);
        check("single_ready_launch", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        check("single_en_pulse", 32'(uart_tx_en), 32'd0);
        check("single_wait_busy", 32'(busy), 32'd1);
        repeat (LAT - 1) step();
        uart_tx_done = 1'b1;
        step();
        uart_tx_done = 1'b0;
        check("single_done_busy", 32'(busy), 32'd0);

        // Watchdog: req1 locks, never gets done; req3 waits
        req_data  = 32'h3C007700;
        req_last  = 4'b1101;
        req_valid = 4'b0010;
        wait_launch(5, at);
        check("wd_data",  32'(uart_tx_data), 32'h77);
        check("wd_grant", 32'(grant_id),     32'd1);
        check("wd_lock",  32'(lock_active),  32'd1);
        req_valid = 4'b1000;
        tat = -1;
        n   = 0;
        while (tat < 0 && n < TO_CYC + 10) begin
            step();
            if (tx_timeout) tat = cyc;
            else if (req_ready != 4'b0000) tat = -2;
            n++;
        end
        check("wd_fired", 32'(tat >= 0), 32'd1);
        check("wd_delay", 32'(tat - at), 32'(TO_CYC));
        check("wd_lock_clear", 32'(lock_active), 32'd0);
        check("wd_busy",  32'(busy),      32'd0);
        check("wd_ready", 32'(req_ready), 32'h8);
        step();
        check("wd_pulse_one", 32'(tx_timeout),   32'd0);
        check("wd_next_en",   32'(uart_tx_en),   32'd1);
        check("wd_next_data", 32'(uart_tx_data), 32'h3C);
        check("wd_next_grant", 32'(grant_id),    32'd3);

        // Spurious done in LAUNCH, then done on the expiry cycle
        req_valid    = '0;
        uart_tx_done = 1'b1;
        step();
        uart_tx_done = 1'b0;
        check("spurious_busy", 32'(busy), 32'd1);
        repeat (TO_CYC - 2) step();
        uart_tx_done = 1'b1;
        step();
        uart_tx_done = 1'b0;
        check("collide_timeout", 32'(tx_timeout), 32'd0);
        check("collide_busy",    32'(busy),       32'd0);

        // Reset in WAIT_DONE with lock held
        req_data  = 32'h005A0000;
        req_last  = 4'b1011;
        req_valid = 4'b0100;
        wait_launch(5, at);
        check("rst_pre_grant", 32'(grant_id), 32'd2);
        req_valid = '0;
        repeat (3) step();
        check("rst_pre_lock", 32'(lock_active), 32'd1);
        check("rst_pre_busy", 32'(busy),        32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (3) step();
        rst_n = 1'b1;
        uart_tx_done = 1'b1;
        step();
        uart_tx_done = 1'b0;
        check("stale_done_busy", 32'(busy),       32'd0);
        check("stale_done_en",   32'(uart_tx_en), 32'd0);
        req_data  = 32'hC3B2A1F0;
        req_last  = 4'hF;
        req_valid = 4'hF;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        wait_launch(5, at);
        check("post_rst_data",  32'(uart_tx_data), 32'hF0);
        check("post_rst_grant", 32'(grant_id),     32'd0);
        req_valid = '0;
        finish_tx();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
